// File: rtl/sha256ctx_sched_pkg.sv
// sha256ctx_sched_pkg: shared constants, FSM encoding and pipeline record types for the round sequencer
package sha256ctx_sched_pkg;
  localparam int ROUNDS   = 64;
  localparam int EDGE_LEN = 8;
  localparam int CTRL_DLY = 2;
  localparam int SAVE_DLY = 6;
  localparam int CNT_W    = 6;
  localparam int WORD_W   = 3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_EDGE,
    ST_FLUSH
  } st_e;
  // What a context asks for in its current slot
  typedef struct packed {
    logic             rdy;
    logic             ld;
    logic             rnd;
    logic             sv;
    logic             dn;
    logic [CNT_W-1:0] cnt;
  } iss_t;
  // One entry of the result-save delay line
  typedef struct packed {
    logic              v;
    logic              dn;
    logic              ctx;
    logic [WORD_W-1:0] word;
  } sv_t;
endpackage

// File: rtl/sha256ctx_sched_fsm.sv
// sha256ctx_sched_fsm: block sequencer and slot counter for one SHA256 context
module sha256ctx_sched_fsm
  import sha256ctx_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic adv_i,
  input  logic start_i,
  output iss_t iss_o,
  output logic busy_o
);
  st_e              state_q, state_d, eff_st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  // State and slot counter advance only in this context's own slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (adv_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // An accepted start turns the IDLE slot into the first LOAD slot, so no slot is wasted
  always_comb begin
    eff_st  = (state_q == ST_IDLE && start_i) ? ST_LOAD : state_q;
    last    = cnt_q == ((eff_st == ST_ROUND) ? CNT_W'(ROUNDS - 1) : CNT_W'(EDGE_LEN - 1));
    state_d = eff_st;
    case (eff_st)
      ST_LOAD, ST_EDGE: state_d = last ? ST_ROUND : eff_st;
      ST_ROUND:         state_d = last ? (start_i ? ST_EDGE : ST_FLUSH) : ST_ROUND;
      ST_FLUSH:         state_d = last ? ST_IDLE : ST_FLUSH;
      default:          state_d = eff_st;
    endcase
    cnt_d = (last || eff_st == ST_IDLE) ? '0 : cnt_q + 1'b1;
  end
  // Slot request decode
  always_comb begin
    iss_o.rdy = start_i && (state_q == ST_IDLE || (state_q == ST_ROUND && last));
    iss_o.ld  = eff_st == ST_LOAD || eff_st == ST_EDGE;
    iss_o.rnd = eff_st == ST_ROUND;
    iss_o.sv  = eff_st == ST_EDGE || eff_st == ST_FLUSH;
    iss_o.dn  = (eff_st == ST_EDGE || eff_st == ST_FLUSH) && last;
    iss_o.cnt = cnt_q;
    busy_o    = state_q != ST_IDLE;
  end
endmodule

// File: rtl/sha256ctx_sched.sv
// sha256ctx_sched: two-context interleaved SHA256 round sequencer with strobe and save delay lines
module sha256ctx_sched
  import sha256ctx_sched_pkg::*;
(
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] start,
  output logic [1:0] ready,
  output logic [1:0] done,
  output logic [1:0] busy,
  output logic       glbl_en,
  output logic       block2ctx_en,
  output logic       S0_rst,
  output logic       S1_CH_rst,
  output logic       T1_rst,
  output logic       D2E_en,
  output logic [3:0] ctx_rd_addr,
  output logic [5:0] k_idx,
  output logic [6:0] w_rd_addr,
  output logic       save_en,
  output logic [3:0] save_addr
);
  logic                     phase_q;
  iss_t                     iss [2];
  iss_t                     cur;
  sv_t                      sv_d;
  sv_t  [SAVE_DLY:0]        sv_q;
  logic [CTRL_DLY:0]        ld_q;
  logic [CTRL_DLY:0]        gen_q;
  logic [1:0]               ready_q;
  logic [3:0]               cra_q;
  logic [CNT_W-1:0]         k_q;
  logic [CNT_W:0]           wra_q;
  for (genvar c = 0; c < 2; c++) begin : g_ctx
    sha256ctx_sched_fsm u_fsm (
      .clk_i  (CLK),
      .rst_ni (rst_n),
      .adv_i  (en && phase_q == 1'(c)),
      .start_i(start[c]),
      .iss_o  (iss[c]),
      .busy_o (busy[c])
    );
  end
  // Pick the context owning this clock and build its save record
  always_comb begin
    cur       = phase_q ? iss[1] : iss[0];
    sv_d.v    = cur.sv;
    sv_d.dn   = cur.dn;
    sv_d.ctx  = cur.sv & phase_q;
    sv_d.word = cur.sv ? cur.cnt[WORD_W-1:0] : '0;
  end
  // Phase and issue-stage address registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      cra_q   <= '0;
      k_q     <= '0;
      wra_q   <= '0;
    end else if (en) begin
      phase_q <= ~phase_q;
      cra_q   <= cur.ld ? {phase_q, cur.cnt[WORD_W-1:0]} : '0;
      k_q     <= cur.rnd ? cur.cnt : '0;
      wra_q   <= cur.rnd ? {phase_q, cur.cnt} : '0;
    end
  end
  // Strobe and save delay lines freeze together with the rest of the sequencer
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= '0;
      sv_q <= '0;
    end else if (en) begin
      ld_q <= {ld_q[CTRL_DLY-1:0], cur.ld};
      sv_q <= {sv_q[SAVE_DLY-1:0], sv_d};
    end
  end
  // Ready pulse and enable pipeline keep running so pulses clear and glbl_en drops while frozen
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= '0;
      gen_q   <= '0;
    end else begin
      ready_q <= (en && cur.rdy) ? (phase_q ? 2'b10 : 2'b01) : '0;
      gen_q   <= {gen_q[CTRL_DLY-1:0], en};
    end
  end
  assign ready        = ready_q;
  assign glbl_en      = gen_q[CTRL_DLY];
  assign block2ctx_en = ld_q[CTRL_DLY];
  assign S0_rst       = ld_q[CTRL_DLY];
  assign S1_CH_rst    = ld_q[CTRL_DLY];
  assign T1_rst       = ld_q[CTRL_DLY];
  assign D2E_en       = ld_q[CTRL_DLY];
  assign ctx_rd_addr  = cra_q;
  assign k_idx        = k_q;
  assign w_rd_addr    = wra_q;
  assign save_en      = sv_q[SAVE_DLY].v;
  assign save_addr    = {sv_q[SAVE_DLY].ctx, sv_q[SAVE_DLY].word};
  // gen_q[0] marks that the save line shifted on the last edge, so done lasts one clock only
  assign done = (sv_q[SAVE_DLY].dn && gen_q[0]) ? (sv_q[SAVE_DLY].ctx ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_sha256ctx_sched.sv
// tb_sha256ctx_sched: scoreboard bench for the two-context SHA256 round sequencer
module tb_sha256ctx_sched;
  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [1:0] start = 2'b00;
  logic [1:0] ready, done, busy;
  logic       glbl_en, block2ctx_en, S0_rst, S1_CH_rst, T1_rst, D2E_en, save_en;
  logic [3:0] ctx_rd_addr, save_addr;
  logic [5:0] k_idx;
  logic [6:0] w_rd_addr;
  int         cyc;
  int         n_chk = 0;
  int         n_fail = 0;
  typedef enum int {S_RDY, S_DONE, S_BUSY, S_GLBL, S_STRB, S_CRA, S_KIDX, S_WRA, S_SVEN, S_SVAD} sig_e;
  typedef struct {
    int          c;
    sig_e        s;
    logic [31:0] v;
  } exp_t;
  exp_t  sb[$];
  string nm[10] = '{"ready", "done", "busy", "glbl_en", "strobes", "ctx_rd_addr", "k_idx", "w_rd_addr", "save_en", "save_addr"};

  sha256ctx_sched dut (
    .CLK(CLK), .rst_n(rst_n), .en(en), .start(start), .ready(ready), .done(done), .busy(busy),
    .glbl_en(glbl_en), .block2ctx_en(block2ctx_en), .S0_rst(S0_rst), .S1_CH_rst(S1_CH_rst),
    .T1_rst(T1_rst), .D2E_en(D2E_en), .ctx_rd_addr(ctx_rd_addr), .k_idx(k_idx),
    .w_rd_addr(w_rd_addr), .save_en(save_en), .save_addr(save_addr)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [31:0] obs(sig_e s);
    case (s)
      S_RDY:   return 32'(ready);
      S_DONE:  return 32'(done);
      S_BUSY:  return 32'(busy);
      S_GLBL:  return 32'(glbl_en);
      S_STRB:  return 32'({block2ctx_en, S0_rst, S1_CH_rst, T1_rst, D2E_en});
      S_CRA:   return 32'(ctx_rd_addr);
      S_KIDX:  return 32'(k_idx);
      S_WRA:   return 32'(w_rd_addr);
      S_SVEN:  return 32'(save_en);
      default: return 32'(save_addr);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void expect_at(int c, sig_e s, int v);
    sb.push_back('{c, s, 32'(v)});
  endfunction

  always @(negedge CLK) begin
    if (rst_n)
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].c == cyc) begin
          chk($sformatf("%s@%0d", nm[int'(sb[i].s)], cyc), obs(sb[i].s), sb[i].v);
          sb.delete(i);
        end
  end

  task automatic wait_cyc(int k);
    while (cyc < k) @(negedge CLK);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 10; s++) chk($sformatf("reset_%s", nm[s]), obs(sig_e'(s)), 0);
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic drain(int lim);
    while (sb.size() != 0 && cyc < lim) @(negedge CLK);
    #1;
    chk("scoreboard_left", 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single ctx0 block: LOAD, 64 rounds, FLUSH, done
    do_reset();
    start = 2'b01;
    expect_at(1, S_RDY, 1);
    expect_at(2, S_RDY, 0);
    expect_at(1, S_BUSY, 1);
    expect_at(5, S_GLBL, 1);
    for (int w = 0; w < 8; w++) begin
      expect_at(1 + 2 * w, S_CRA, w);
      expect_at(2 + 2 * w, S_CRA, 0);
      expect_at(3 + 2 * w, S_STRB, 31);
      expect_at(4 + 2 * w, S_STRB, 0);
      expect_at(151 + 2 * w, S_SVEN, 1);
      expect_at(151 + 2 * w, S_SVAD, w);
      expect_at(152 + 2 * w, S_SVEN, 0);
    end
    expect_at(19, S_STRB, 0);
    for (int r = 0; r < 64; r++) begin
      expect_at(17 + 2 * r, S_KIDX, r);
      expect_at(17 + 2 * r, S_WRA, r);
    end
    expect_at(143, S_RDY, 0);
    expect_at(145, S_CRA, 0);
    expect_at(147, S_STRB, 0);
    expect_at(164, S_DONE, 0);
    expect_at(165, S_DONE, 1);
    expect_at(166, S_DONE, 0);
    expect_at(158, S_BUSY, 1);
    expect_at(160, S_BUSY, 0);
    wait_cyc(1);
    start = 2'b00;
    drain(200);
    // both contexts held: back-to-back EDGE slots, 144-clock block period
    do_reset();
    start = 2'b11;
    expect_at(1, S_RDY, 1);
    expect_at(2, S_RDY, 2);
    expect_at(143, S_RDY, 1);
    expect_at(144, S_RDY, 2);
    expect_at(145, S_RDY, 0);
    expect_at(286, S_RDY, 0);
    expect_at(287, S_RDY, 1);
    expect_at(288, S_RDY, 2);
    for (int w = 0; w < 8; w++) begin
      expect_at(2 + 2 * w, S_CRA, 8 + w);
      expect_at(145 + 2 * w, S_CRA, w);
      expect_at(146 + 2 * w, S_CRA, 8 + w);
      expect_at(151 + 2 * w, S_SVAD, w);
      expect_at(152 + 2 * w, S_SVAD, 8 + w);
      expect_at(152 + 2 * w, S_SVEN, 1);
    end
    for (int c = 147; c <= 162; c++) expect_at(c, S_STRB, 31);
    expect_at(165, S_DONE, 1);
    expect_at(166, S_DONE, 2);
    expect_at(161, S_KIDX, 0);
    expect_at(163, S_KIDX, 1);
    expect_at(161, S_WRA, 0);
    expect_at(162, S_WRA, 64);
    expect_at(163, S_WRA, 1);
    expect_at(164, S_WRA, 65);
    expect_at(200, S_BUSY, 3);
    drain(300);
    start = 2'b00;
    // en low for 5 clocks at k_idx=30
    do_reset();
    start = 2'b01;
    expect_at(77, S_KIDX, 30);
    for (int c = 78; c <= 82; c++) begin
      expect_at(c, S_KIDX, 30);
      expect_at(c, S_RDY, 0);
    end
    expect_at(80, S_STRB, 0);
    expect_at(79, S_GLBL, 1);
    expect_at(80, S_GLBL, 0);
    expect_at(84, S_GLBL, 0);
    expect_at(85, S_GLBL, 1);
    expect_at(83, S_KIDX, 0);
    expect_at(84, S_KIDX, 31);
    expect_at(84, S_WRA, 31);
    expect_at(86, S_KIDX, 32);
    expect_at(156, S_SVEN, 1);
    expect_at(156, S_SVAD, 0);
    expect_at(162, S_SVAD, 3);
    expect_at(169, S_DONE, 0);
    expect_at(170, S_DONE, 1);
    wait_cyc(1);
    start = 2'b00;
    wait_cyc(77);
    en = 1'b0;
    wait_cyc(82);
    en = 1'b1;
    drain(200);
    // reset at round 40 aborts the block; a fresh start begins at LOAD
    do_reset();
    start = 2'b01;
    expect_at(97, S_KIDX, 40);
    wait_cyc(1);
    start = 2'b00;
    wait_cyc(97);
    do_reset();
    start = 2'b01;
    expect_at(1, S_RDY, 1);
    expect_at(1, S_BUSY, 1);
    for (int w = 0; w < 8; w++) begin
      expect_at(1 + 2 * w, S_CRA, w);
      expect_at(3 + 2 * w, S_STRB, 31);
    end
    for (int c = 1; c <= 20; c++) expect_at(c, S_DONE, 0);
    expect_at(17, S_KIDX, 0);
    expect_at(19, S_WRA, 1);
    wait_cyc(1);
    start = 2'b00;
    drain(40);
    // start pulsed mid-ROUND only: ignored, block flushes to IDLE
    do_reset();
    start = 2'b01;
    for (int c = 56; c <= 59; c++) expect_at(c, S_RDY, 0);
    expect_at(57, S_KIDX, 20);
    expect_at(143, S_RDY, 0);
    expect_at(145, S_CRA, 0);
    expect_at(147, S_STRB, 0);
    expect_at(151, S_SVEN, 1);
    expect_at(151, S_SVAD, 0);
    expect_at(165, S_DONE, 1);
    expect_at(158, S_BUSY, 1);
    expect_at(160, S_BUSY, 0);
    expect_at(180, S_BUSY, 0);
    wait_cyc(1);
    start = 2'b00;
    wait_cyc(55);
    start = 2'b01;
    wait_cyc(58);
    start = 2'b00;
    drain(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
